fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Fetch/execute controller for the 8-bit computer.
//  - Owns the program counter and sequences instruction fetch from program memory via a req/ready handshake.
//  - Latches the fetched byte into the instruction register and hands it to the execute unit.
//  - Applies PC increment, jump loads and halt.
//  - Sits between the run/step front panel, program memory and the execute datapath.
// PARAMETERS
//  ADDR_W    8      PC / memory address width
//  RESET_PC  8'h00  PC value loaded on reset
// PORTS
//  clk        in   1       system clock; all state changes on rising edge
//  reset      in   1       synchronous, active-high reset
//  run        in   1       level: free-running execution while high
//  step       in   1       pulse: execute exactly one instruction (IDLE only)
//  mem_req    out  1       fetch request, held high until mem_ready
//  mem_addr   out  ADDR_W  fetch address (= pc)
//  mem_ready  in   1       memory data valid this cycle (sampled only when mem_req=1)
//  mem_rdata  in   8       fetched instruction byte
//  ir         out  8       instruction register
//  ir_valid   out  1       one-cycle pulse: new ir available
//  exec_done  in   1       execute unit finished current instruction
//  jump       in   1       with exec_done: load pc from jump_addr
//  jump_addr  in   ADDR_W  jump target
//  halt       in   1       with exec_done: enter HALT
//  pc         out  ADDR_W  program counter
//  halted     out  1       high in HALT state
//  state      out  2       FSM state (debug)
// BEHAVIOUR
//  Reset: all of the following take effect at the clock edge where reset=1, including mid-FETCH/EXEC.
//  - Register values: pc=RESET_PC, ir=8'h00, ir_valid=0, state=IDLE.
//  - Derived outputs: mem_req=0, halted=0.
//  - A memory response still in flight when reset asserts is ignored.
//  States (encoding):
//  - IDLE=2'b00
//  - FETCH=2'b01
//  - EXEC=2'b10
//  - HALT=2'b11
//  Derived outputs: mem_req=(state==FETCH); mem_addr=pc; halted=(state==HALT).
//  IDLE:
//  - run=1 -> FETCH.
//  - else step=1 -> FETCH, single-step mode.
//  - run takes priority over step.
//  FETCH:
//  - Wait for mem_ready=1; on that edge: ir<=mem_rdata, pc<=pc+1, -> EXEC.
//  - ir_valid=1 for exactly the next cycle.
//  - run/step changes are ignored while in FETCH.
//  EXEC:
//  - Wait for exec_done=1; it may be high in the first EXEC cycle.
//  - On that edge, priority: halt -> HALT (pc unchanged, jump ignored);
//    else jump -> pc<=jump_addr; then run ? FETCH : IDLE.
//  - A single-step always returns to IDLE unless run is high.
//  HALT:
//  - Terminal; leaves only via reset.
//  - run, step, jump and exec_done are ignored.
//  Latency:
//  - run rises, sampled at edge k -> mem_req high in cycle k+1.
//  - Zero-wait memory -> ir_valid in cycle k+2.
//  - Minimum throughput with run held: 2 cycles/instruction.
//  Arithmetic: pc+1 is modulo 2^ADDR_W (8'hFF -> 8'h00); no overflow flag.
//  step pulses outside IDLE are dropped, not queued.
// STRUCTURE
//  - Package seq_pkg: state localparams (IDLE/FETCH/EXEC/HALT), ADDR_W default, RESET_PC default.
//  - Sub-module pc_reg: ADDR_W register with sync reset to RESET_PC, load (jump) and inc.
//    Load has priority over inc.
//  - Remaining logic (FSM, ir, ir_valid) lives in fetch_sequencer.
// TESTING
//  1. Reset: reset high 2 cycles -> pc=00, ir=00, mem_req=0, ir_valid=0, halted=0, state=00.
//  2. Run, zero-wait memory, exec_done tied high, mem_rdata=addr -> ir=00,01,02..., one ir_valid per 2 cycles.
//  3. Step with run=0, one 1-cycle step -> exactly one fetch, pc 00->01, return to IDLE;
//     a second step while in EXEC is ignored.
//  4. Memory wait states: mem_ready delayed 3 cycles -> mem_req stays high and mem_addr stable for 4 cycles.
//  5. Jump/halt: exec_done+jump, jump_addr=8'h40 -> next mem_addr=40.
//     exec_done+halt+jump -> HALT, pc unchanged, no further mem_req.
//  6. Wrap and reset mid-op:
//     - pc=FF fetch -> pc=00.
//     - Reset asserted during FETCH with mem_req high -> mem_req=0 and pc=00 next cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants for the 8-bit fetch/execute sequencer:
// FSM encodings and default address width / reset PC.
package seq_pkg;

  localparam int         SEQ_ADDR_W   = 8;
  localparam logic [7:0] SEQ_RESET_PC = 8'h00;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_FETCH = 2'b01;
  localparam logic [1:0] ST_EXEC  = 2'b10;
  localparam logic [1:0] ST_HALT  = 2'b11;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: sync reset, load, increment.
// Load wins over increment; increment wraps modulo 2^ADDR_W.
module pc_reg
  import seq_pkg::*;
#(
  parameter int                ADDR_W   = SEQ_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] load_val_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: jump target, then +1, else hold.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute controller: owns the PC, fetches over a
// req/ready handshake, latches IR and waits for exec_done.
module fetch_sequencer
  import seq_pkg::*;
#(
  parameter int                ADDR_W   = SEQ_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(SEQ_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        ir,
  output logic              ir_valid,
  input  logic              exec_done,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [1:0]        state
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [7:0] ir_q;
  logic [7:0] ir_d;
  logic       ir_valid_q;
  logic       ir_valid_d;
  logic       pc_load;
  logic       pc_inc;

  pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk       (clk),
    .reset     (reset),
    .load_i    (pc_load),
    .inc_i     (pc_inc),
    .load_val_i(jump_addr),
    .pc_o      (pc)
  );

  // Sequencing: IDLE -> FETCH -> EXEC -> IDLE/FETCH, HALT sticky.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run || step) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_ready) begin
          ir_d       = mem_rdata;
          ir_valid_d = 1'b1;
          pc_inc     = 1'b1;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          if (halt) begin
            state_d = ST_HALT;
          end else begin
            pc_load = jump;
            state_d = run ? ST_FETCH : ST_IDLE;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // State, IR and the one-cycle ir_valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ir_q       <= 8'h00;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign mem_req  = (state_q == ST_FETCH);
  assign mem_addr = pc;
  assign halted   = (state_q == ST_HALT);
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign state    = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random
// stimulus, every cycle checked against a behavioural model.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, step, mem_ready, exec_done, jump, halt;
  logic [7:0] mem_rdata, jump_addr;
  logic       mem_req, ir_valid, halted;
  logic [7:0] mem_addr, ir, pc;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // model: mode 0 idle, 1 awaiting memory, 2 awaiting execute, 3 stopped
  int       m_mode;
  bit [7:0] m_pc, m_ir;
  bit       m_irv;
  bit       auto_data;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .step     (step),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .ir       (ir),
    .ir_valid (ir_valid),
    .exec_done(exec_done),
    .jump     (jump),
    .jump_addr(jump_addr),
    .halt     (halt),
    .pc       (pc),
    .halted   (halted),
    .state    (state)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_mode));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("mem_addr", 32'(mem_addr), 32'(m_pc));
    chk("mem_req", 32'(mem_req), 32'(m_mode == 1));
    chk("halted", 32'(halted), 32'(m_mode == 3));
    chk("ir", 32'(ir), 32'(m_ir));
    chk("ir_valid", 32'(ir_valid), 32'(m_irv));
  endtask

  // One clock: predict from current inputs, step, compare at negedge.
  task automatic tick();
    int       n_mode;
    bit [7:0] n_pc, n_ir;
    bit       n_irv;
    if (auto_data) mem_rdata = m_pc;
    n_mode = m_mode;
    n_pc   = m_pc;
    n_ir   = m_ir;
    n_irv  = 0;
    if (reset) begin
      n_mode = 0;
      n_pc   = 8'h00;
      n_ir   = 8'h00;
    end else if (m_mode == 0) begin
      if (run || step) n_mode = 1;
    end else if (m_mode == 1) begin
      if (mem_ready) begin
        n_ir   = mem_rdata;
        n_pc   = 8'((int'(m_pc) + 1) % 256);
        n_irv  = 1;
        n_mode = 2;
      end
    end else if (m_mode == 2) begin
      if (exec_done) begin
        if (halt) n_mode = 3;
        else begin
          if (jump) n_pc = jump_addr;
          n_mode = run ? 1 : 0;
        end
      end
    end
    @(posedge clk);
    m_mode = n_mode;
    m_pc   = n_pc;
    m_ir   = n_ir;
    m_irv  = n_irv;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    run = 0; step = 0; mem_ready = 0; exec_done = 0;
    jump = 0; halt = 0; jump_addr = 8'h00; mem_rdata = 8'h00;
    auto_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    int n, k;
    logic [7:0] a0;
    reset = 1;
    idle_inputs();
    m_mode = 0; m_pc = 0; m_ir = 0; m_irv = 0;
    @(negedge clk);

    // 1: reset state
    do_reset();
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);

    // 2: free run, zero-wait memory, data = address
    run = 1; mem_ready = 1; exec_done = 1; auto_data = 1;
    n = 0; k = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ir_valid) begin
        chk("run_ir", 32'(ir), 32'(k));
        k++;
      end
      n += int'(ir_valid);
    end
    chk("run_rate", 32'(n), 32'd5);

    // 3: single step, extra step in EXEC dropped
    do_reset();
    step = 1; tick();
    step = 0; mem_ready = 1; tick();
    chk("step_exec", 32'(state), 32'h2);
    step = 1; mem_ready = 0; tick();
    step = 0; exec_done = 1; tick();
    exec_done = 0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n += int'(mem_req);
    end
    chk("step_pc", 32'(pc), 32'h01);
    chk("step_idle", 32'(state), 32'h0);
    chk("step_nofetch", 32'(n), 32'd0);

    // 4: three wait states
    do_reset();
    run = 1; exec_done = 1;
    tick();
    a0 = mem_addr;
    n = int'(mem_req);
    for (int i = 0; i < 3; i++) begin
      tick();
      n += int'(mem_req);
      chk("wait_addr", 32'(mem_addr), 32'(a0));
    end
    mem_ready = 1; tick();
    chk("wait_cycles", 32'(n), 32'd4);
    chk("wait_req_lo", 32'(mem_req), 32'h0);

    // 5: jump then halt
    do_reset();
    run = 1; mem_ready = 1; jump = 1; jump_addr = 8'h40;
    tick(); tick();
    exec_done = 1; tick();
    chk("jump_addr", 32'(mem_addr), 32'h40);
    exec_done = 0; tick();
    halt = 1; exec_done = 1; jump_addr = 8'h10; tick();
    chk("halt_st", 32'(halted), 32'h1);
    chk("halt_pc", 32'(pc), 32'h41);
    step = 1; halt = 0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n += int'(mem_req);
    end
    chk("halt_noreq", 32'(n), 32'd0);

    // 6: wrap FF -> 00, then reset during FETCH
    do_reset();
    run = 1; mem_ready = 1;
    tick(); tick();
    jump = 1; jump_addr = 8'hFF; exec_done = 1; tick();
    jump = 0; exec_done = 0; tick();
    chk("wrap_pc", 32'(pc), 32'h00);
    jump = 1; jump_addr = 8'h20; exec_done = 1; mem_ready = 0; tick();
    chk("pre_rst_req", 32'(mem_req), 32'h1);
    reset = 1; mem_ready = 1; tick();
    chk("midrst_req", 32'(mem_req), 32'h0);
    chk("midrst_pc", 32'(pc), 32'h00);
    reset = 0;

    // random stimulus against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      run       = ($urandom_range(0, 3) != 0);
      step      = $urandom_range(0, 1) == 1;
      mem_ready = $urandom_range(0, 2) != 0;
      mem_rdata = 8'($urandom);
      exec_done = $urandom_range(0, 2) != 0;
      jump      = $urandom_range(0, 3) == 0;
      jump_addr = 8'($urandom);
      halt      = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
